// File: rtl/limbus_cpu_cpu_debug_ocimem.sv
// Debug RAM access engine for the JTAG debug slave. Turns the decoded
// take_* strobes into single read/write accesses on the on-chip debug RAM
// with an auto-incrementing word address, returns read data on MonDReg and
// keeps a sticky flag for commands that were dropped because of overlap.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a strobe; the only state that accepts one
//   WR      | ram_we pulse at the current address, then address + 1
//   RD      | ram_re pulse at the current address
//   RD_WAIT | counting out the RAM read latency, capture on last cycle
module limbus_cpu_cpu_debug_ocimem #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              mon_valid,
    output logic              ocimem_busy,
    output logic              ocimem_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    // RD_WAIT down-counter start value; terminal count 0 is the capture cycle.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_nxt;
    logic [1:0]        wait_cnt;
    logic [1:0]        wait_cnt_nxt;
    logic              overrun_nxt;
    logic              mon_load;

    logic              can_accept;
    logic              acc_a;
    logic              acc_b;
    logic              acc_n;
    logic              drop;
    logic [ADDR_W-1:0] jdo_addr;
    logic              unused_jdo;

    // jdo bits outside the address/flag and write-data fields carry nothing here.
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign jdo_addr = ADDR_W'(jdo[33:26]);

    // Strobe arbitration: a > b > no_action_a, and only from an idle engine.
    assign can_accept = (state == IDLE) && !ocimem_busy;
    assign acc_a = can_accept && take_action_ocimem_a;
    assign acc_b = can_accept && take_action_ocimem_b && !take_action_ocimem_a;
    assign acc_n = can_accept && take_no_action_ocimem_a
                   && !take_action_ocimem_a && !take_action_ocimem_b;

    // Any strobe that is not the accepted one is lost.
    assign drop = can_accept
                ? ((take_action_ocimem_a & take_action_ocimem_b)
                   | (take_action_ocimem_a & take_no_action_ocimem_a)
                   | (take_action_ocimem_b & take_no_action_ocimem_a))
                : (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a);

    assign ram_addr  = addr;
    assign ram_wdata = wdata_q;

    // Next-state, datapath updates and RAM strobes.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        wdata_nxt    = wdata_q;
        wait_cnt_nxt = wait_cnt;
        overrun_nxt  = ocimem_overrun;
        mon_load     = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        // A clear carried by an accepted address load beats a same-cycle drop.
        if (drop) begin
            overrun_nxt = 1'b1;
        end
        if (acc_a && jdo[24]) begin
            overrun_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (acc_a) begin
                    addr_nxt = jdo_addr;
                    if (jdo[25]) begin
                        state_nxt = RD;
                    end
                end else if (acc_b) begin
                    wdata_nxt = jdo[34:3];
                    state_nxt = WR;
                end else if (acc_n) begin
                    state_nxt = RD;
                end
            end
            WR: begin
                ram_we    = 1'b1;
                addr_nxt  = addr + ADDR_W'(1);
                state_nxt = IDLE;
            end
            RD: begin
                ram_re       = 1'b1;
                wait_cnt_nxt = LAT_LOAD;
                state_nxt    = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    mon_load  = 1'b1;
                    addr_nxt  = addr + ADDR_W'(1);
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; busy and mon_valid are registered so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr           <= '0;
            wdata_q        <= '0;
            wait_cnt       <= '0;
            MonDReg        <= '0;
            mon_valid      <= 1'b0;
            ocimem_busy    <= 1'b0;
            ocimem_overrun <= 1'b0;
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            wdata_q        <= wdata_nxt;
            wait_cnt       <= wait_cnt_nxt;
            mon_valid      <= mon_load;
            ocimem_busy    <= (state_nxt != IDLE);
            ocimem_overrun <= overrun_nxt;
            if (mon_load) begin
                MonDReg <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_limbus_cpu_cpu_debug_ocimem.sv
// Bench for limbus_cpu_cpu_debug_ocimem with RD_LAT=2, ADDR_W=8: directed
// vector table, transaction-level model for random commands, and hand
// sequences for overlap drops and reset in the middle of a read.
module tb_limbus_cpu_cpu_debug_ocimem;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;
    logic [31:0]       MonDReg;
    logic              mon_valid;
    logic              ocimem_busy;
    logic              ocimem_overrun;

    int n_checks = 0;
    int n_errors = 0;

    limbus_cpu_cpu_debug_ocimem #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_we                  (ram_we),
        .ram_re                  (ram_re),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .mon_valid               (mon_valid),
        .ocimem_busy             (ocimem_busy),
        .ocimem_overrun          (ocimem_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of the debug RAM.
    function automatic logic [31:0] pat(input logic [7:0] a);
        return {8'hC0, a, 8'h5A, ~a};
    endfunction

    // Debug RAM: stored as a delta from pat() so it starts out defined.
    // Read data is only valid exactly RD_LAT clocks after ram_re.
    bit [31:0] mem_d   [256];
    bit [31:0] rd_pipe [RD_LAT];
    bit        rd_v    [RD_LAT];

    always @(posedge clk) begin
        if (ram_we) mem_d[ram_addr] <= ram_wdata ^ pat(ram_addr);
        rd_pipe[0] <= mem_d[ram_addr] ^ pat(ram_addr);
        rd_v[0]    <= ram_re;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_v[i]    <= rd_v[i-1];
        end
    end

    assign ram_rdata = rd_v[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'h0BAD_F00D;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: host-visible address, sticky flag, RAM image.
    int          m_addr;
    logic        m_ovr;
    logic [31:0] m_mem [256];

    task automatic model_cmd(input logic a, input logic b, input logic n,
                             input logic [7:0] ad, input logic rd, input logic clr,
                             input logic [31:0] data, input logic inj,
                             output logic e_we, output logic e_re,
                             output logic [7:0] e_addr, output logic [31:0] e_data,
                             output logic e_ovr);
        int cnt;
        cnt    = int'(a) + int'(b) + int'(n);
        e_we   = 1'b0;
        e_re   = 1'b0;
        e_addr = 8'h00;
        e_data = 32'h0;
        if (cnt > 1) m_ovr = 1'b1;
        if (a) begin
            m_addr = int'(ad);
            if (clr) m_ovr = 1'b0;
            e_re = rd;
        end else if (b) begin
            e_we = 1'b1;
        end else if (n) begin
            e_re = 1'b1;
        end
        if (e_we) begin
            e_addr = 8'(m_addr);
            e_data = data;
            m_mem[m_addr] = data;
            m_addr = (m_addr + 1) % 256;
        end
        if (e_re) begin
            e_addr = 8'(m_addr);
            e_data = m_mem[m_addr];
            m_addr = (m_addr + 1) % 256;
            if (inj) m_ovr = 1'b1;
        end
        e_ovr = m_ovr;
    endtask

    // Issue one command in the current (idle) cycle and check the whole access
    // window. inj drops a b strobe into the first RD_WAIT cycle of a read.
    task automatic run_cmd(input string tag, input logic a, input logic b, input logic n,
                           input logic [7:0] ad, input logic rd, input logic clr,
                           input logic [31:0] data, input logic inj,
                           input logic e_we, input logic e_re,
                           input logic [7:0] e_addr, input logic [31:0] e_data,
                           input logic e_ovr);
        logic [37:0] j;
        j = {6'($urandom), $urandom};
        if (b) j[34:3] = data;
        if (a) begin
            j[33:26] = ad;
            j[25]    = rd;
            j[24]    = clr;
        end
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = {6'($urandom), $urandom};
        chk({tag, ".we1"},   32'(ram_we), 32'(e_we));
        chk({tag, ".re1"},   32'(ram_re), 32'(e_re));
        chk({tag, ".busy1"}, 32'(ocimem_busy), 32'(e_we | e_re));
        chk({tag, ".mv1"},   32'(mon_valid), 32'd0);
        if (e_we | e_re) chk({tag, ".addr"}, 32'(ram_addr), 32'(e_addr));
        if (e_we) begin
            chk({tag, ".wdata"}, ram_wdata, e_data);
            @(posedge clk); #1;
            chk({tag, ".we2"},   32'(ram_we), 32'd0);
            chk({tag, ".busy2"}, 32'(ocimem_busy), 32'd0);
        end
        if (e_re) begin
            for (int k = 2; k <= 1 + RD_LAT; k++) begin
                @(posedge clk); #1;
                take_action_ocimem_b = 1'b0;
                if (inj && k == 2) begin
                    take_action_ocimem_b = 1'b1;
                    jdo = {6'($urandom), $urandom};
                end
                chk({tag, ".re_w"},   32'(ram_re), 32'd0);
                chk({tag, ".we_w"},   32'(ram_we), 32'd0);
                chk({tag, ".busy_w"}, 32'(ocimem_busy), 32'd1);
                chk({tag, ".mv_w"},   32'(mon_valid), 32'd0);
            end
            @(posedge clk); #1;
            take_action_ocimem_b = 1'b0;
            chk({tag, ".mv"},     32'(mon_valid), 32'd1);
            chk({tag, ".mon"},    MonDReg, e_data);
            chk({tag, ".busy_e"}, 32'(ocimem_busy), 32'd0);
            chk({tag, ".we_e"},   32'(ram_we), 32'd0);
            chk({tag, ".re_e"},   32'(ram_re), 32'd0);
        end
        chk({tag, ".ovr"}, 32'(ocimem_overrun), 32'(e_ovr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".addr"},  32'(ram_addr), 32'd0);
        chk({tag, ".wdata"}, ram_wdata, 32'd0);
        chk({tag, ".we"},    32'(ram_we), 32'd0);
        chk({tag, ".re"},    32'(ram_re), 32'd0);
        chk({tag, ".mon"},   MonDReg, 32'd0);
        chk({tag, ".mv"},    32'(mon_valid), 32'd0);
        chk({tag, ".busy"},  32'(ocimem_busy), 32'd0);
        chk({tag, ".ovr"},   32'(ocimem_overrun), 32'd0);
    endtask

    typedef struct {
        logic        a, b, n;
        logic [7:0]  ad;
        logic        rd, clr;
        logic [31:0] data;
        logic        e_we, e_re;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ovr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic        m_we, m_re, m_o;
        logic [7:0]  m_a;
        logic [31:0] m_d;
        logic        a, b, n, rd, clr, inj;
        logic [7:0]  ad;
        logic [31:0] data;
        logic [2:0]  s;

        //            a  b  n  addr   rd clr data           we re addr   data           ovr
        vecs[0]  = '{1, 0, 0, 8'h10, 0, 0, 32'h0,         0, 0, 8'h00, 32'h0,         0};
        vecs[1]  = '{0, 1, 0, 8'h00, 0, 0, 32'hDEADBEEF,  1, 0, 8'h10, 32'hDEADBEEF,  0};
        vecs[2]  = '{1, 0, 0, 8'h10, 1, 0, 32'h0,         0, 1, 8'h10, 32'hDEADBEEF,  0};
        vecs[3]  = '{0, 0, 1, 8'h00, 0, 0, 32'h0,         0, 1, 8'h11, 32'hC0115AEE,  0};
        vecs[4]  = '{1, 0, 0, 8'hFF, 0, 0, 32'h0,         0, 0, 8'h00, 32'h0,         0};
        vecs[5]  = '{0, 1, 0, 8'h00, 0, 0, 32'h12345678,  1, 0, 8'hFF, 32'h12345678,  0};
        vecs[6]  = '{0, 0, 1, 8'h00, 0, 0, 32'h0,         0, 1, 8'h00, 32'hC0005AFF,  0};
        vecs[7]  = '{1, 1, 1, 8'h40, 0, 0, 32'h0,         0, 0, 8'h00, 32'h0,         1};
        vecs[8]  = '{1, 0, 0, 8'h40, 1, 1, 32'h0,         0, 1, 8'h40, 32'hC0405ABF,  0};
        vecs[9]  = '{1, 1, 1, 8'h20, 1, 1, 32'h0,         0, 1, 8'h20, 32'hC0205ADF,  0};
        vecs[10] = '{0, 1, 1, 8'h00, 0, 0, 32'hCAFEF00D,  1, 0, 8'h21, 32'hCAFEF00D,  1};
        vecs[11] = '{1, 0, 0, 8'hFF, 1, 1, 32'h0,         0, 1, 8'hFF, 32'h12345678,  0};
        vecs[12] = '{0, 0, 1, 8'h00, 0, 0, 32'h0,         0, 1, 8'h00, 32'hC0005AFF,  0};

        for (int i = 0; i < 256; i++) m_mem[i] = pat(8'(i));
        m_addr = 0;
        m_ovr  = 1'b0;

        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: constant expectations; model tracks along.
        for (int i = 0; i < 13; i++) begin
            model_cmd(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].ad, vecs[i].rd, vecs[i].clr,
                      vecs[i].data, 1'b0, m_we, m_re, m_a, m_d, m_o);
            run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].ad,
                    vecs[i].rd, vecs[i].clr, vecs[i].data, 1'b0,
                    vecs[i].e_we, vecs[i].e_re, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_ovr);
        end

        // b strobed during RD_WAIT is dropped and flags overrun; a with clear resets it.
        model_cmd(0, 0, 1, 8'h00, 0, 0, 32'h0, 1'b1, m_we, m_re, m_a, m_d, m_o);
        run_cmd("drop_rdwait", 0, 0, 1, 8'h00, 0, 0, 32'h0, 1'b1, 1'b0, 1'b1, 8'h01,
                32'hC0015AFE, 1'b1);
        model_cmd(1, 0, 0, 8'h80, 0, 1, 32'h0, 1'b0, m_we, m_re, m_a, m_d, m_o);
        run_cmd("clear_ovr", 1, 0, 0, 8'h80, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00,
                32'h0, 1'b0);

        // Random commands against the transaction model.
        for (int it = 0; it < 300; it++) begin
            s    = 3'($urandom_range(1, 7));
            a    = s[2];
            b    = s[1];
            n    = s[0];
            ad   = 8'($urandom);
            rd   = 1'($urandom);
            clr  = ($urandom_range(0, 3) == 0);
            data = $urandom;
            inj  = ($urandom_range(0, 7) == 0);
            model_cmd(a, b, n, ad, rd, clr, data, inj, m_we, m_re, m_a, m_d, m_o);
            run_cmd($sformatf("rnd%0d", it), a, b, n, ad, rd, clr, data, inj,
                    m_we, m_re, m_a, m_d, m_o);
        end

        // Reset asserted in RD_WAIT, with an overrun pending from a dropped b.
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b1;
        jdo = {6'($urandom), $urandom};
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        chk("mid.busy_pre", 32'(ocimem_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        m_addr = 0;
        m_ovr  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_cmd(0, 0, 1, 8'h00, 0, 0, 32'h0, 1'b0, m_we, m_re, m_a, m_d, m_o);
        run_cmd("post_reset", 0, 0, 1, 8'h00, 0, 0, 32'h0, 1'b0, m_we, m_re, m_a, m_d, m_o);
        chk("post_reset.addr0", 32'(m_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
